// File: rtl/pci_parity_pkg.sv
// Shared constants, phase type and the lane parity helper for the PCI parity unit.
package pci_parity_pkg;
  localparam int LANE_W      = 32;
  localparam int BE_PER_LANE = 4;

  typedef enum logic {
    PH_DATA = 1'b0,
    PH_ADDR = 1'b1
  } phase_e;

  // Even parity: the result makes the lane plus its PAR bit carry an even count of ones.
  function automatic logic lane_parity(input logic [LANE_W-1:0]      ad,
                                       input logic [BE_PER_LANE-1:0] cbe_n);
    return ^{ad, cbe_n};
  endfunction
endpackage

// File: rtl/pci_parity_unit_if.sv
// Bus-side signal bundle of the PCI parity unit; slave is the unit, master the surrounding agent.
interface pci_parity_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0]   AD;
  logic [DATA_W/8-1:0] CBE_N;
  logic                PAR_IN;
  logic                PAR64_IN;
  logic                GEN_EN;
  logic                CHK_EN;
  logic                ADDR_PH;
  logic                WIDE;
  logic                PERR_EN;
  logic                SERR_EN;
  logic                STAT_CLR;
  logic                PAR_OUT;
  logic                PAR_OE;
  logic                PAR64_OUT;
  logic                PAR64_OE;
  logic                PERR_N;
  logic                PERR_OE;
  logic                SERR_N;
  logic                DPE;
  logic                SSE;
  logic [CNT_W-1:0]    ERR_CNT;

  modport master (
    output AD, CBE_N, PAR_IN, PAR64_IN, GEN_EN, CHK_EN, ADDR_PH, WIDE,
           PERR_EN, SERR_EN, STAT_CLR,
    input  PAR_OUT, PAR_OE, PAR64_OUT, PAR64_OE, PERR_N, PERR_OE, SERR_N,
           DPE, SSE, ERR_CNT
  );

  modport slave (
    input  AD, CBE_N, PAR_IN, PAR64_IN, GEN_EN, CHK_EN, ADDR_PH, WIDE,
           PERR_EN, SERR_EN, STAT_CLR,
    output PAR_OUT, PAR_OE, PAR64_OUT, PAR64_OE, PERR_N, PERR_OE, SERR_N,
           DPE, SSE, ERR_CNT
  );
endinterface

// File: rtl/pci_par_lane.sv
// One 32-bit parity lane: parity of this cycle's AD/C/BE# registered for the next cycle,
// together with the generate and check valids that travel alongside it.
module pci_par_lane
  import pci_parity_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANE_W-1:0]      ad,
  input  logic [BE_PER_LANE-1:0] cbe_n,
  input  logic                   gen_en,
  input  logic                   chk_en,
  output logic                   par,
  output logic                   gen_vld,
  output logic                   chk_vld
);
  logic par_d, par_q;
  logic gen_vld_d, gen_vld_q;
  logic chk_vld_d, chk_vld_q;

  // The same registered parity serves both the driven PAR and the received-phase check.
  always_comb begin
    par_d     = lane_parity(ad, cbe_n);
    gen_vld_d = gen_en;
    chk_vld_d = chk_en;
  end

  // Lane pipeline register; reset drops any pending phase immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q     <= 1'b0;
      gen_vld_q <= 1'b0;
      chk_vld_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      gen_vld_q <= gen_vld_d;
      chk_vld_q <= chk_vld_d;
    end
  end

  assign par     = par_q;
  assign gen_vld = gen_vld_q;
  assign chk_vld = chk_vld_q;
endmodule

// File: rtl/pci_parity_unit.sv
// PCI PAR/PAR64 generator and checker with PERR#/SERR# signalling, sticky DPE/SSE
// and a saturating parity error counter.
module pci_parity_unit
  import pci_parity_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  pci_parity_unit_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic   p_lo, p_hi, gen_lo, gen_hi, chk_lo, chk_hi;
  logic   chk_err, data_err, addr_err, perr_hit, serr_hit;
  phase_e phase_d, phase_q;
  logic   perr_n_d, perr_n_q, perr_oe_d, perr_oe_q, serr_n_d, serr_n_q;
  logic   dpe_d, dpe_q, sse_d, sse_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  pci_par_lane u_lane_lo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .ad      (bus.AD[LANE_W-1:0]),
    .cbe_n   (bus.CBE_N[BE_PER_LANE-1:0]),
    .gen_en  (bus.GEN_EN),
    .chk_en  (bus.CHK_EN),
    .par     (p_lo),
    .gen_vld (gen_lo),
    .chk_vld (chk_lo)
  );

  // High lane exists only on a 64-bit bus; its valids carry the registered WIDE qualifier.
  generate
    if (DATA_W == 64) begin : g_hi
      pci_par_lane u_lane_hi (
        .clk     (CLK),
        .rst_n   (RST_N),
        .ad      (bus.AD[DATA_W-1:LANE_W]),
        .cbe_n   (bus.CBE_N[DATA_W/8-1:BE_PER_LANE]),
        .gen_en  (bus.GEN_EN & bus.WIDE),
        .chk_en  (bus.CHK_EN & bus.WIDE),
        .par     (p_hi),
        .gen_vld (gen_hi),
        .chk_vld (chk_hi)
      );
    end else begin : g_no_hi
      logic unused_wide;
      assign unused_wide = bus.WIDE;
      assign p_hi   = 1'b0;
      assign gen_hi = 1'b0;
      assign chk_hi = 1'b0;
    end
  endgenerate

  // Stage-2 compare against PAR/PAR64 sampled one clock after the phase, then error response.
  always_comb begin
    chk_err  = chk_lo & ((bus.PAR_IN != p_lo) | (chk_hi & (bus.PAR64_IN != p_hi)));
    data_err = chk_err & (phase_q == PH_DATA);
    addr_err = chk_err & (phase_q == PH_ADDR);
    perr_hit = data_err & bus.PERR_EN;
    serr_hit = addr_err & bus.PERR_EN & bus.SERR_EN;

    phase_d   = bus.CHK_EN ? (bus.ADDR_PH ? PH_ADDR : PH_DATA) : phase_q;
    perr_n_d  = ~perr_hit;
    // PERR# keeps its enable one clock past the last low so it is driven high before release.
    perr_oe_d = perr_hit | ~perr_n_q;
    serr_n_d  = ~serr_hit;

    dpe_d = dpe_q;
    sse_d = sse_q;
    cnt_d = cnt_q;
    if (bus.STAT_CLR) begin
      dpe_d = 1'b0;
      sse_d = 1'b0;
      cnt_d = '0;
    end
    // A new error in the same cycle as the clear wins over it.
    if (chk_err) begin
      dpe_d = 1'b1;
      cnt_d = (cnt_d == CNT_MAX) ? cnt_d : cnt_d + CNT_W'(1);
    end
    if (serr_hit) sse_d = 1'b1;
  end

  // Error-reporting and status registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_q   <= PH_DATA;
      perr_n_q  <= 1'b1;
      perr_oe_q <= 1'b0;
      serr_n_q  <= 1'b1;
      dpe_q     <= 1'b0;
      sse_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      perr_n_q  <= perr_n_d;
      perr_oe_q <= perr_oe_d;
      serr_n_q  <= serr_n_d;
      dpe_q     <= dpe_d;
      sse_q     <= sse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PAR_OUT   = p_lo;
  assign bus.PAR_OE    = gen_lo;
  assign bus.PAR64_OUT = p_hi;
  assign bus.PAR64_OE  = gen_hi;
  assign bus.PERR_N    = perr_n_q;
  assign bus.PERR_OE   = perr_oe_q;
  assign bus.SERR_N    = serr_n_q;
  assign bus.DPE       = dpe_q;
  assign bus.SSE       = sse_q;
  assign bus.ERR_CNT   = cnt_q;
endmodule

// File: tb/tb_pci_parity_unit.sv
// Directed bench for pci_parity_unit (64-bit bus, 2-bit counter) with a cycle-stamped scoreboard.
module tb_pci_parity_unit;
  localparam int DW = 64;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pci_parity_unit_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
  pci_parity_unit #(.DATA_W(DW), .CNT_W(CW)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  typedef enum int {O_PAR, O_PAR_OE, O_PAR64, O_PAR64_OE, O_PERR_N, O_PERR_OE,
                    O_SERR_N, O_DPE, O_SSE, O_CNT} osel_e;
  typedef struct {int due; osel_e sel; logic [7:0] exp; int id;} exp_t;

  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] obs(input osel_e s);
    case (s)
      O_PAR:      return 8'(bus.PAR_OUT);
      O_PAR_OE:   return 8'(bus.PAR_OE);
      O_PAR64:    return 8'(bus.PAR64_OUT);
      O_PAR64_OE: return 8'(bus.PAR64_OE);
      O_PERR_N:   return 8'(bus.PERR_N);
      O_PERR_OE:  return 8'(bus.PERR_OE);
      O_SERR_N:   return 8'(bus.SERR_N);
      O_DPE:      return 8'(bus.DPE);
      O_SSE:      return 8'(bus.SSE);
      default:    return 8'(bus.ERR_CNT);
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic exp_at(input int dly, input osel_e s, input logic [7:0] e, input int id);
    exp_t x;
    x.due = cyc + dly; x.sel = s; x.exp = e; x.id = id;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t keep[$];
    osel_e s;
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        s = sb[i].sel;
        cmp($sformatf("%s#%0d", s.name(), sb[i].id), obs(s), sb[i].exp);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drain();
  endtask

  task automatic reset_values(input string tag);
    logic [7:0] rv [10];
    osel_e s;
    rv = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 10; i++) begin
      s = osel_e'(i);
      cmp($sformatf("%s_%s", tag, s.name()), obs(s), rv[i]);
    end
  endtask

  task automatic clear_status(input int id);
    bus.STAT_CLR = 1'b1;
    exp_at(1, O_DPE, 8'd0, id); exp_at(1, O_SSE, 8'd0, id); exp_at(1, O_CNT, 8'd0, id);
    tick();
    bus.STAT_CLR = 1'b0;
  endtask

  initial begin
    bus.AD = '0; bus.CBE_N = '0; bus.PAR_IN = 1'b0; bus.PAR64_IN = 1'b0;
    bus.GEN_EN = 1'b0; bus.CHK_EN = 1'b0; bus.ADDR_PH = 1'b0; bus.WIDE = 1'b0;
    bus.PERR_EN = 1'b0; bus.SERR_EN = 1'b0; bus.STAT_CLR = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_values("rst");
    rst_n = 1'b1;
    tick();

    // Narrow generate: 5 has two ones -> PAR 0; enable drops after one phase.
    bus.GEN_EN = 1'b1; bus.AD = 64'h5; bus.CBE_N = 8'h00; bus.WIDE = 1'b0;
    exp_at(1, O_PAR, 8'd0, 1); exp_at(1, O_PAR_OE, 8'd1, 1); exp_at(1, O_PAR64_OE, 8'd0, 1);
    tick();
    bus.GEN_EN = 1'b0;
    exp_at(1, O_PAR_OE, 8'd0, 2);
    tick();

    // Back-to-back: wide phase (lo 1 one, hi 2 ones + BE#4) then narrow all-zero phase.
    bus.GEN_EN = 1'b1; bus.WIDE = 1'b1; bus.AD = 64'h0000_0003_0000_0001; bus.CBE_N = 8'h10;
    exp_at(1, O_PAR, 8'd1, 3); exp_at(1, O_PAR_OE, 8'd1, 3);
    exp_at(1, O_PAR64, 8'd1, 3); exp_at(1, O_PAR64_OE, 8'd1, 3);
    tick();
    bus.WIDE = 1'b0; bus.AD = 64'h0; bus.CBE_N = 8'h00;
    exp_at(1, O_PAR, 8'd0, 4); exp_at(1, O_PAR_OE, 8'd1, 4); exp_at(1, O_PAR64_OE, 8'd0, 4);
    tick();
    bus.GEN_EN = 1'b0;
    exp_at(1, O_PAR_OE, 8'd0, 5);
    tick();

    // Data-phase error with PERR_EN: low, driven high, then released.
    bus.CHK_EN = 1'b1; bus.ADDR_PH = 1'b0; bus.AD = 64'h5; bus.CBE_N = 8'h00;
    tick();
    bus.CHK_EN = 1'b0; bus.PAR_IN = 1'b1; bus.PERR_EN = 1'b1;
    exp_at(1, O_PERR_N, 8'd0, 6); exp_at(1, O_PERR_OE, 8'd1, 6); exp_at(1, O_DPE, 8'd1, 6);
    exp_at(1, O_CNT, 8'd1, 6); exp_at(1, O_SERR_N, 8'd1, 6);
    exp_at(2, O_PERR_N, 8'd1, 7); exp_at(2, O_PERR_OE, 8'd1, 7);
    exp_at(3, O_PERR_OE, 8'd0, 8); exp_at(3, O_DPE, 8'd1, 8);
    tick();
    bus.PAR_IN = 1'b0;
    tick(); tick();
    clear_status(9);

    // Data-phase error with PERR_EN=0: DPE/count still record it, PERR# untouched.
    bus.CHK_EN = 1'b1; bus.AD = 64'h5;
    tick();
    bus.CHK_EN = 1'b0; bus.PAR_IN = 1'b1; bus.PERR_EN = 1'b0;
    exp_at(1, O_PERR_N, 8'd1, 10); exp_at(1, O_PERR_OE, 8'd0, 10);
    exp_at(1, O_DPE, 8'd1, 10); exp_at(1, O_CNT, 8'd1, 10);
    tick();
    bus.PAR_IN = 1'b0;
    tick();
    clear_status(11);

    // Address-phase error: 35 ones -> p_lo 1, PAR_IN 0 is wrong; SERR# one cycle.
    bus.CHK_EN = 1'b1; bus.ADDR_PH = 1'b1; bus.AD = 64'hFFFF_FFFE; bus.CBE_N = 8'h0F;
    tick();
    bus.CHK_EN = 1'b0; bus.ADDR_PH = 1'b0; bus.PAR_IN = 1'b0; bus.PERR_EN = 1'b1; bus.SERR_EN = 1'b1;
    exp_at(1, O_SERR_N, 8'd0, 12); exp_at(1, O_SSE, 8'd1, 12); exp_at(1, O_PERR_N, 8'd1, 12);
    exp_at(1, O_PERR_OE, 8'd0, 12); exp_at(1, O_DPE, 8'd1, 12);
    exp_at(2, O_SERR_N, 8'd1, 13); exp_at(2, O_SSE, 8'd1, 13); exp_at(2, O_PERR_N, 8'd1, 13);
    tick(); tick();
    clear_status(14);

    // Address-phase error with SERR_EN=0: DPE only.
    bus.CHK_EN = 1'b1; bus.ADDR_PH = 1'b1;
    tick();
    bus.CHK_EN = 1'b0; bus.ADDR_PH = 1'b0; bus.SERR_EN = 1'b0;
    exp_at(1, O_SERR_N, 8'd1, 15); exp_at(1, O_SSE, 8'd0, 15); exp_at(1, O_DPE, 8'd1, 15);
    tick();
    clear_status(16);

    // 64-bit phase: low lane correct, high lane (one 1) wrong.
    bus.CHK_EN = 1'b1; bus.WIDE = 1'b1; bus.AD = 64'h1_0000_0000; bus.CBE_N = 8'h00;
    tick();
    bus.CHK_EN = 1'b0; bus.WIDE = 1'b0; bus.PAR_IN = 1'b0; bus.PAR64_IN = 1'b0;
    exp_at(1, O_PERR_N, 8'd0, 17); exp_at(1, O_DPE, 8'd1, 17); exp_at(1, O_CNT, 8'd1, 17);
    tick(); tick(); tick();
    clear_status(18);

    // Same data as a narrow phase: the high lane is not checked.
    bus.CHK_EN = 1'b1; bus.WIDE = 1'b0;
    tick();
    bus.CHK_EN = 1'b0;
    exp_at(1, O_PERR_N, 8'd1, 19); exp_at(1, O_DPE, 8'd0, 19); exp_at(1, O_CNT, 8'd0, 19);
    tick();

    // Five back-to-back data errors: continuous PERR# low, counter saturates at 3.
    bus.AD = 64'h5; bus.CBE_N = 8'h00; bus.ADDR_PH = 1'b0; bus.PERR_EN = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      bus.CHK_EN = (i < 5);
      bus.PAR_IN = (i >= 1);
      if (i >= 1) begin
        exp_at(1, O_PERR_N, 8'd0, 20 + i); exp_at(1, O_PERR_OE, 8'd1, 20 + i);
        exp_at(1, O_CNT, 8'((i < 3) ? i : 3), 20 + i);
      end
      tick();
    end
    bus.CHK_EN = 1'b0; bus.PAR_IN = 1'b0;
    exp_at(1, O_PERR_N, 8'd1, 26); exp_at(1, O_PERR_OE, 8'd1, 26); exp_at(1, O_CNT, 8'd3, 26);
    exp_at(2, O_PERR_OE, 8'd0, 27);
    tick(); tick();

    // Sixth error coincides with STAT_CLR: the set wins.
    bus.CHK_EN = 1'b1;
    tick();
    bus.CHK_EN = 1'b0; bus.PAR_IN = 1'b1; bus.STAT_CLR = 1'b1;
    exp_at(1, O_CNT, 8'd1, 28); exp_at(1, O_DPE, 8'd1, 28);
    tick();
    bus.PAR_IN = 1'b0; bus.STAT_CLR = 1'b0;
    tick(); tick();

    // Reset while PERR# is low and PAR is being driven.
    bus.CHK_EN = 1'b1;
    tick();
    bus.CHK_EN = 1'b0; bus.PAR_IN = 1'b1; bus.GEN_EN = 1'b1;
    exp_at(1, O_PERR_N, 8'd0, 29); exp_at(1, O_PAR_OE, 8'd1, 29);
    tick();
    bus.PAR_IN = 1'b0; bus.GEN_EN = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_values("async_rst");
    cmp("scoreboard_empty", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pci_parity_unit.md
Name: pci_parity_unit

Overview:
Registered PCI parity generator and checker, parametrised for a 32- or 64-bit AD bus. It produces PAR (and PAR64) one clock after the AD/C/BE# phase it covers. It checks received PAR/PAR64 against the same one-clock-late timing and signals errors with PCI-compliant PERR#/SERR# timing. It also maintains sticky status bits and a saturating error counter for the configuration-space block.

Parameters:
DATA_W, 32, AD width; legal values 32 or 64.
CNT_W, 8, width of the parity error counter.

Ports:
CLK  in  1  PCI clock; all logic on rising edge.
RST_N  in  1  asynchronous active-low reset.
AD  in  DATA_W  AD bus value (driven or sampled) this cycle.
CBE_N  in  DATA_W/8  C/BE# value this cycle.
PAR_IN  in  1  sampled PAR, valid one cycle after the phase it covers.
PAR64_IN  in  1  sampled PAR64, same timing; ignored when DATA_W=32.
GEN_EN  in  1  this agent drives AD/CBE_N this cycle.
CHK_EN  in  1  the phase this cycle is received and must be checked.
ADDR_PH  in  1  qualifies CHK_EN as an address phase (else data phase).
WIDE  in  1  64-bit phase; forced 0 internally when DATA_W=32.
PERR_EN  in  1  command register Parity Error Response.
SERR_EN  in  1  command register SERR# Enable.
STAT_CLR  in  1  one-cycle write-1-to-clear of DPE, SSE and ERR_CNT.
PAR_OUT  out  1  generated PAR.
PAR_OE  out  1  PAR output enable.
PAR64_OUT  out  1  generated PAR64.
PAR64_OE  out  1  PAR64 output enable.
PERR_N  out  1  PERR# drive value.
PERR_OE  out  1  PERR# output enable.
SERR_N  out  1  SERR# drive value (open-drain; driven only when low).
DPE  out  1  sticky Detected Parity Error.
SSE  out  1  sticky Signaled System Error.
ERR_CNT  out  CNT_W  saturating count of detected parity errors.

Behaviour:
- Parity rule (even parity):
  - Low lane: p_lo = XOR of AD[31:0] and CBE_N[3:0].
  - High lane: p_hi = XOR of AD[63:32] and CBE_N[7:4].
  - The count of ones across a lane plus its PAR bit is even.
- Reset values: PAR_OUT=0, PAR_OE=0, PAR64_OUT=0, PAR64_OE=0, PERR_N=1, PERR_OE=0, SERR_N=1, DPE=0, SSE=0, ERR_CNT=0. Internal pipeline valids clear. Reset mid-operation drops all pending checks and output enables immediately.
- Generation, phase in cycle N with GEN_EN=1:
  - Cycle N+1: PAR_OUT=p_lo, PAR_OE=1.
  - If WIDE=1, also PAR64_OUT=p_hi and PAR64_OE=1 in N+1.
  - Enables deassert in the cycle after the last phase's parity.
  - Back-to-back phases give continuous PAR_OE.
- Checking stage 1, cycle N with CHK_EN=1: register p_lo, p_hi, WIDE and ADDR_PH.
- Checking stage 2, cycle N+1:
  - err = (PAR_IN != p_lo) OR (WIDE and PAR64_IN != p_hi).
  - Each phase is independent; back-to-back checks are fully pipelined.
- Data-phase error (ADDR_PH=0) in check cycle N+1:
  - DPE sets at the N+2 edge, regardless of PERR_EN.
  - If PERR_EN=1: PERR_N=0 in N+2, then PERR_N=1 in N+3.
  - PERR_OE=1 in N+2 and N+3, so PERR# is driven high one clock before release.
  - Consecutive errors keep PERR_N low continuously; PERR_OE stays high until one cycle after the last low.
- Address-phase error (ADDR_PH=1):
  - DPE sets.
  - If PERR_EN=1 and SERR_EN=1: SERR_N=0 for exactly cycle N+2, and SSE sets.
  - PERR_N is not asserted for address-phase errors.
- ERR_CNT:
  - Increments by 1 per detected error, address or data.
  - Saturates at 2^CNT_W-1; no wrap.
- STAT_CLR:
  - Clears DPE, SSE and ERR_CNT.
  - If a new error is recorded in the same cycle, the set wins: DPE=1 and ERR_CNT=1.
- GEN_EN and CHK_EN in the same cycle are legal; the two paths are independent.
- PERR_EN/SERR_EN are sampled in the cycle the error is evaluated (N+1).

Decomposition:
- Package pci_parity_pkg holds:
  - LANE_W=32 and BE_PER_LANE=4.
  - An enum for phase type (ADDR, DATA).
  - Function lane_parity(ad, cbe_n).
- Sub-module pci_par_lane: registered XOR reduction of one 32-bit lane with valid pipelining. It is instantiated once, plus a second time under generate when DATA_W=64.

Test Plan:
- Generate: GEN_EN=1, AD=32'h0000_0005, CBE_N=4'h0 -> next cycle PAR_OUT=0, PAR_OE=1; the cycle after that PAR_OE=0.
- Data parity error: CHK_EN=1, ADDR_PH=0, AD=32'h0000_0005, CBE_N=0, then PAR_IN=1, PERR_EN=1 -> PERR_N=0 two cycles after the phase, PERR_N=1/PERR_OE=1 the next cycle, DPE=1, ERR_CNT=1.
- Address parity error: ADDR_PH=1, AD=32'hFFFF_FFFE, CBE_N=4'hF, PAR_IN=0, PERR_EN=1, SERR_EN=1 -> SERR_N low for one cycle, SSE=1, PERR_N stays 1.
- 64-bit, DATA_W=64, WIDE=1: AD=64'h1_0000_0000, CBE_N=0, correct PAR_IN=0, wrong PAR64_IN=0 -> error flagged via the high lane and PERR_N asserted.
- Counter: CNT_W=2 with 5 consecutive errors -> PERR_N low for 5 consecutive cycles and ERR_CNT saturates at 3. Then STAT_CLR alongside a sixth error -> ERR_CNT=1, DPE=1.
- Reset: assert RST_N=0 while PERR_N=0 -> all outputs return to reset values asynchronously.
